// File: rtl/urt_tx_resp_if.sv
// urt_tx_resp_if
//   Bundles the signals of the response framer: the read-request pulses from
//   the command parser, the req/vld value-fetch handshake toward the parameter
//   source, the UART TX FIFO write port, and the busy flag.
//
//   Signals
//     i_rd_req       [19:0]  one-hot read-request pulses, bit k = parameter k
//     o_val_req              value fetch request, held until i_val_vld
//     o_val_sel      [4:0]   parameter index being fetched
//     i_val_dat      [31:0]  value returned by the parameter source
//     i_val_vld              single-cycle qualifier for i_val_dat
//     o_urttx_wr_en          TX FIFO write strobe
//     o_urttx_wr_dat [7:0]   TX FIFO write byte
//     i_urttx_full           TX FIFO programmable-full flag
//     o_busy                 framer not idle
//
//   Modports
//     master  the framer itself (drives the o_* signals)
//     slave   the surroundings: parser, parameter source, TX FIFO
interface urt_tx_resp_if;
  logic [19:0] i_rd_req;
  logic        o_val_req;
  logic [4:0]  o_val_sel;
  logic [31:0] i_val_dat;
  logic        i_val_vld;
  logic        o_urttx_wr_en;
  logic [7:0]  o_urttx_wr_dat;
  logic        i_urttx_full;
  logic        o_busy;

  modport master (
    input  i_rd_req, i_val_dat, i_val_vld, i_urttx_full,
    output o_val_req, o_val_sel, o_urttx_wr_en, o_urttx_wr_dat, o_busy
  );

  modport slave (
    output i_rd_req, i_val_dat, i_val_vld, i_urttx_full,
    input  o_val_req, o_val_sel, o_urttx_wr_en, o_urttx_wr_dat, o_busy
  );
endinterface

// File: rtl/urt_tx_resp.sv
// urt_tx_resp
//   Response framer behind the UART command parser. Read-request pulses for
//   the 20 channel-0/1 parameters are collected in a pending set and served
//   lowest index first. For each one the value is fetched from the parameter
//   source (req/vld handshake, with a timeout), then an 8-byte frame
//     EB 90 stat id d[31:24] d[23:16] d[15:8] d[7:0]
//   is written into the UART TX FIFO, one byte per write. stat is B0 for a
//   good fetch and BF (with data FFFFFFFF) on timeout. id is the BCD-looking
//   code 00..09 for channel 0 and 10..19 for channel 1.
//
//   Ports
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   urt_tx_resp_if.master (request, fetch, TX FIFO and busy signals)
//
//   Parameter
//     VAL_TIMEOUT  cycles o_val_req stays high without i_val_vld before a
//                  timeout frame is sent (1..65535)
module urt_tx_resp #(
  parameter int unsigned VAL_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  urt_tx_resp_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(VAL_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [19:0] pending;
  logic [19:0] clr_mask;
  logic [4:0]  low_idx;
  logic [4:0]  idx;
  logic [15:0] tmo_cnt;
  logic [31:0] dat;
  logic [7:0]  stat;
  logic [3:0]  cnt;
  logic        grant;
  logic        take_vld;
  logic        take_tmo;
  logic        issue;

  // Channel 1 indices 10..19 map to ids 0x10..0x19.
  function automatic logic [7:0] frame_id(input logic [4:0] ix);
    return (ix < 5'd10) ? {3'b000, ix} : ({3'b000, ix} + 8'd6);
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0]  n,
                                            input logic [7:0]  st,
                                            input logic [4:0]  ix,
                                            input logic [31:0] d);
    logic [7:0] b;
    case (n)
      3'd0:    b = 8'hEB;
      3'd1:    b = 8'h90;
      3'd2:    b = st;
      3'd3:    b = frame_id(ix);
      3'd4:    b = d[31:24];
      3'd5:    b = d[23:16];
      3'd6:    b = d[15:8];
      default: b = d[7:0];
    endcase
    return b;
  endfunction

  // Lowest set pending bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    low_idx = '0;
    for (int k = 19; k >= 0; k--) begin
      if (pending[k]) low_idx = 5'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // cnt runs to 8 in SEND: value 8 is the cycle in which byte 7 lands in the
  // FIFO, so the frame is fully written before the framer reports idle.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    take_vld  = 1'b0;
    take_tmo  = 1'b0;
    issue     = 1'b0;
    clr_mask  = '0;
    case (state)
      IDLE: begin
        if (|pending) begin
          grant     = 1'b1;
          clr_mask  = 20'd1 << low_idx;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (bus.i_val_vld) begin
          take_vld  = 1'b1;
          state_nxt = SEND;
        end else if (tmo_cnt == TMO_LAST) begin
          take_tmo  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (cnt == 4'd8)              state_nxt = IDLE;
        else if (!bus.i_urttx_full)   issue     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers. A new request ORs in after the clear, so a re-request
  // of the index just granted pends again.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending            <= '0;
      idx                <= '0;
      tmo_cnt            <= '0;
      cnt                <= '0;
      bus.o_urttx_wr_en  <= 1'b0;
      bus.o_urttx_wr_dat <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | bus.i_rd_req;
      if (grant) begin
        idx     <= low_idx;
        tmo_cnt <= '0;
      end else if (state == FETCH) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (take_vld || take_tmo) cnt <= '0;
      else if (issue)           cnt <= cnt + 4'd1;
      // Full is sampled here, one cycle ahead of the write it gates.
      bus.o_urttx_wr_en <= issue;
      if (issue) bus.o_urttx_wr_dat <= frame_byte(cnt[2:0], stat, idx, dat);
    end
  end

  // Fetched value and status; pure data, no reset.
  always_ff @(posedge clk) begin
    if (take_vld) begin
      dat  <= bus.i_val_dat;
      stat <= 8'hB0;
    end else if (take_tmo) begin
      dat  <= 32'hFFFF_FFFF;
      stat <= 8'hBF;
    end
  end

  assign bus.o_val_req = (state == FETCH);
  assign bus.o_val_sel = idx;
  assign bus.o_busy    = (state != IDLE);

endmodule

// File: tb/tb_urt_tx_resp.sv
// tb_urt_tx_resp
//   Bench for urt_tx_resp. A parameter-source model answers each fetch after a
//   per-index delay (or never), a monitor collects every FIFO write, and the
//   expected frames are built from the frame rules with plain arithmetic.
module tb_urt_tx_resp;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  urt_tx_resp_if bif();

  urt_tx_resp #(.VAL_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Parameter source settings: delay in cycles after o_val_req rises (>= TMO
  // means the source never answers) and the value it returns.
  int          src_dly[20];
  logic [31:0] src_val[20];

  // Monitor state
  logic       full_q;
  logic [7:0] got_q[$];
  int         wr_cyc[$];
  int         sel_log[$];
  int         req_cyc[$];
  int         req_hi;
  int         stall_bad;
  int         req_age;

  always @(posedge clk) full_q <= bif.i_urttx_full;

  initial begin
    bif.i_val_vld = 1'b0;
    bif.i_val_dat = '0;
    req_age   = 0;
    req_hi    = 0;
    stall_bad = 0;
    forever begin
      @(negedge clk);
      if (bif.o_urttx_wr_en) begin
        got_q.push_back(bif.o_urttx_wr_dat);
        wr_cyc.push_back(cyc);
        if (full_q) stall_bad++;
      end
      if (bif.o_val_req) begin
        if (req_age == 0) begin
          sel_log.push_back(int'(bif.o_val_sel));
          req_cyc.push_back(cyc);
        end
        req_hi++;
        bif.i_val_vld = (req_age == src_dly[bif.o_val_sel]);
        bif.i_val_dat = bif.i_val_vld ? src_val[bif.o_val_sel] : $urandom();
        req_age++;
      end else begin
        bif.i_val_vld = 1'b0;
        req_age       = 0;
      end
    end
  end

  // Expected frame for parameter k: id shows channel and parameter number as
  // two hex digits (tens digit = channel).
  function automatic logic [63:0] model_frame(input int k);
    logic [7:0]  id;
    logic [7:0]  st;
    logic [31:0] d;
    bit          timed_out;
    timed_out = (src_dly[k] >= TMO);
    id = {4'(k / 10), 4'(k % 10)};
    st = timed_out ? 8'hBF : 8'hB0;
    d  = timed_out ? 32'hFFFF_FFFF : src_val[k];
    return {8'hEB, 8'h90, st, id, d};
  endfunction

  function automatic logic [63:0] pop_frame();
    logic [63:0] f = '0;
    for (int i = 0; i < 8; i++) begin
      f = {f[55:0], got_q.pop_front()};
    end
    return f;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete();
    wr_cyc.delete();
    sel_log.delete();
    req_cyc.delete();
    req_hi    = 0;
    stall_bad = 0;
  endtask

  task automatic pulse(input logic [19:0] mask, output int n);
    step();
    n = cyc;
    bif.i_rd_req = mask;
    step();
    bif.i_rd_req = '0;
  endtask

  task automatic wait_quiet(input int budget, input bit jitter, output bit ok);
    int idle_run = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (jitter) bif.i_urttx_full = ($urandom_range(0, 3) == 0);
      if (!bif.o_busy) idle_run++;
      else             idle_run = 0;
      if (idle_run >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    bif.i_urttx_full = 1'b0;
  endtask

  task automatic wait_bytes(input int nb, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (got_q.size() >= nb) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    total++; if (bif.o_val_req !== 1'b0) begin bad++; $display("FAIL reset_val_req: got %b want 0", bif.o_val_req); end
    total++; if (bif.o_val_sel !== 5'd0) begin bad++; $display("FAIL reset_val_sel: got %0d want 0", bif.o_val_sel); end
    total++; if (bif.o_urttx_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", bif.o_urttx_wr_en); end
    total++; if (bif.o_urttx_wr_dat !== 8'h00) begin bad++; $display("FAIL reset_wr_dat: got %h want 00", bif.o_urttx_wr_dat); end
    total++; if (bif.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bif.o_busy); end
  endtask

  task automatic test_single();
    int n;
    bit ok;
    logic [63:0] f;
    clear_logs();
    src_dly[3] = 2;
    src_val[3] = 32'h1234_5678;
    pulse(20'h0_0008, n);
    wait_quiet(300, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done: busy did not settle within budget"); end
    total++; if (!(sel_log.size() == 1 && sel_log[0] == 3)) begin bad++; $display("FAIL single_sel: got %p want '{3}", sel_log); end
    total++; if (!(req_cyc.size() == 1 && req_cyc[0] - n == 2)) begin bad++; $display("FAIL single_req_latency: got %p want '{%0d}", req_cyc, n + 2); end
    total++; if (!(wr_cyc.size() == 8 && wr_cyc[0] == n + 6 && wr_cyc[7] == n + 13)) begin bad++; $display("FAIL single_wr_timing: got %p want %0d..%0d", wr_cyc, n + 6, n + 13); end
    total++;
    if (got_q.size() != 8) begin
      bad++; $display("FAIL single_count: got %0d want 8", got_q.size());
    end else begin
      f = pop_frame();
      if (f !== 64'hEB90_B003_1234_5678) begin bad++; $display("FAIL single_frame: got %h want eb90b00312345678", f); end
    end
    total++; if (bif.o_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", bif.o_busy); end
  endtask

  task automatic test_ch1_priority();
    int n;
    bit ok;
    logic [63:0] f;
    clear_logs();
    src_dly[10] = 1; src_val[10] = 32'h0000_000B;
    src_dly[19] = 1; src_val[19] = 32'h0000_000A;
    src_val[10] = 32'h0000_000A;
    src_val[19] = 32'h0000_000B;
    pulse(20'h8_0400, n);
    wait_quiet(300, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL ch1_done: busy did not settle within budget"); end
    total++;
    if (got_q.size() != 16) begin
      bad++; $display("FAIL ch1_count: got %0d want 16", got_q.size());
    end else begin
      f = pop_frame();
      if (f !== 64'hEB90_B010_0000_000A) begin bad++; $display("FAIL ch1_first: got %h want eb90b0100000000a", f); end
      total++;
      f = pop_frame();
      if (f !== 64'hEB90_B019_0000_000B) begin bad++; $display("FAIL ch1_second: got %h want eb90b0190000000b", f); end
    end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    logic [63:0] f;
    clear_logs();
    src_dly[0] = 1000;
    pulse(20'h0_0001, n);
    wait_quiet(300, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_done: busy did not settle within budget"); end
    total++; if (req_hi != TMO) begin bad++; $display("FAIL timeout_req_len: got %0d want %0d", req_hi, TMO); end
    total++;
    if (got_q.size() != 8) begin
      bad++; $display("FAIL timeout_count: got %0d want 8", got_q.size());
    end else begin
      f = pop_frame();
      if (f !== 64'hEB90_BF00_FFFF_FFFF) begin bad++; $display("FAIL timeout_frame: got %h want eb90bf00ffffffff", f); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit ok;
    logic [63:0] f;
    logic [63:0] exp;
    clear_logs();
    src_dly[7] = 1;
    src_val[7] = $urandom();
    exp = model_frame(7);
    pulse(20'h0_0080, n);
    wait_bytes(3, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_start: got %0d bytes want 3", got_q.size()); end
    bif.i_urttx_full = 1'b1;
    repeat (5) step();
    bif.i_urttx_full = 1'b0;
    wait_quiet(300, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_done: busy did not settle within budget"); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall_writes: got %0d want 0", stall_bad); end
    total++; if (!(wr_cyc.size() == 8 && wr_cyc[7] - wr_cyc[0] == 12)) begin bad++; $display("FAIL bp_span: got %p want span 12", wr_cyc); end
    total++;
    if (got_q.size() != 8) begin
      bad++; $display("FAIL bp_count: got %0d want 8", got_q.size());
    end else begin
      f = pop_frame();
      if (f !== exp) begin bad++; $display("FAIL bp_frame: got %h want %h", f, exp); end
    end
  endtask

  task automatic test_rerequest();
    int n;
    bit ok;
    logic [63:0] f;
    logic [63:0] exp;
    clear_logs();
    src_dly[5] = 1;
    src_val[5] = $urandom();
    exp = model_frame(5);
    pulse(20'h0_0020, n);
    wait_bytes(1, ok);
    pulse(20'h0_0020, n);
    wait_quiet(400, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rereq_done: busy did not settle within budget"); end
    total++; if (sel_log.size() != 2) begin bad++; $display("FAIL rereq_fetches: got %0d want 2", sel_log.size()); end
    total++;
    if (got_q.size() != 16) begin
      bad++; $display("FAIL rereq_count: got %0d want 16", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        f = pop_frame();
        if (f !== exp) begin bad++; $display("FAIL rereq_frame%0d: got %h want %h", i, f, exp); end
        if (i == 0) total++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bit ok;
    int late_wr = 0;
    int late_busy = 0;
    logic [63:0] exp;
    logic [39:0] head;
    clear_logs();
    src_dly[2] = 1;
    src_val[2] = $urandom();
    src_dly[9] = 1;
    exp = model_frame(2);
    pulse(20'h0_0004, n);
    wait_bytes(1, ok);
    pulse(20'h0_0200, n);
    wait_bytes(5, ok);
    total++; if (got_q.size() != 5) begin bad++; $display("FAIL rst_mid_pos: got %0d bytes want 5", got_q.size()); end
    rst = 1'b1;
    step();
    total++; if (bif.o_urttx_wr_en !== 1'b0) begin bad++; $display("FAIL rst_mid_wr_en: got %b want 0", bif.o_urttx_wr_en); end
    total++; if (bif.o_urttx_wr_dat !== 8'h00) begin bad++; $display("FAIL rst_mid_wr_dat: got %h want 00", bif.o_urttx_wr_dat); end
    total++; if (bif.o_val_req !== 1'b0 || bif.o_val_sel !== 5'd0) begin bad++; $display("FAIL rst_mid_val: got req=%b sel=%0d want 0/0", bif.o_val_req, bif.o_val_sel); end
    total++; if (bif.o_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bif.o_busy); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bif.o_urttx_wr_en) late_wr++;
      if (bif.o_busy) late_busy++;
    end
    total++; if (late_wr != 0 || late_busy != 0) begin bad++; $display("FAIL rst_mid_quiet: got writes=%0d busy=%0d want 0/0", late_wr, late_busy); end
    total++;
    if (got_q.size() != 5) begin
      bad++; $display("FAIL rst_mid_count: got %0d want 5", got_q.size());
    end else begin
      head = '0;
      for (int i = 0; i < 5; i++) head = {head[31:0], got_q.pop_front()};
      if (head !== exp[63:24]) begin bad++; $display("FAIL rst_mid_head: got %h want %h", head, exp[63:24]); end
    end
  endtask

  task automatic test_random();
    int n;
    bit ok;
    int nbits;
    logic [19:0] mask;
    logic [63:0] f;
    logic [63:0] exp;
    for (int it = 0; it < 25; it++) begin
      clear_logs();
      mask = 20'($urandom()) & 20'($urandom());
      if (mask == '0) mask = 20'd1 << $urandom_range(0, 19);
      for (int k = 0; k < 20; k++) begin
        src_dly[k] = $urandom_range(0, 9);
        src_val[k] = $urandom();
      end
      nbits = $countones(mask);
      pulse(mask, n);
      wait_quiet(3000, 1'b1, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand%0d_done: busy did not settle within budget", it); end
      total++; if (stall_bad != 0) begin bad++; $display("FAIL rand%0d_stall: got %0d writes under full want 0", it, stall_bad); end
      total++;
      if (got_q.size() != nbits * 8) begin
        bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, got_q.size(), nbits * 8);
      end else begin
        for (int k = 0; k < 20; k++) begin
          if (mask[k]) begin
            exp = model_frame(k);
            f = pop_frame();
            total++;
            if (f !== exp) begin bad++; $display("FAIL rand%0d_frame_k%0d: got %h want %h", it, k, f, exp); end
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bif.i_rd_req     = '0;
    bif.i_urttx_full = 1'b0;
    for (int k = 0; k < 20; k++) begin
      src_dly[k] = 1;
      src_val[k] = $urandom();
    end
    test_reset();
    test_single();
    test_ch1_priority();
    test_timeout();
    test_backpressure();
    test_rerequest();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
